// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer that owns the HI/LO registers.
// One shared add/subtract path serves mult/multu (shift-add) and div/divu
// (restoring divide). Signed ops run on magnitudes, with the sign fixed in SIGN.
//
// Ports:
//   i_clk, i_rst       clock; synchronous active-high reset
//   i_con_Start        start request, sampled in IDLE/DONE only
//   i_con_Op           00 mult, 01 multu, 10 div, 11 divu
//   i_data_A/B         rs / rt operands, captured at start
//   i_con_MtHi/MtLo    write i_data_A into HI/LO when idle and not starting
//   o_data_Hi/Lo       HI/LO registers
//   o_con_Busy         high in CALC and SIGN
//   o_con_Done         one-cycle pulse once HI/LO hold a new result
module muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_con_Start,
  input  logic [1:0]       i_con_Op,
  input  logic [WIDTH-1:0] i_data_A,
  input  logic [WIDTH-1:0] i_data_B,
  input  logic             i_con_MtHi,
  input  logic             i_con_MtLo,
  output logic [WIDTH-1:0] o_data_Hi,
  output logic [WIDTH-1:0] o_data_Lo,
  output logic             o_con_Busy,
  output logic             o_con_Done
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StSign, StDone} state_e;

  state_e               state_q, state_d;
  // Multiply: {upper accumulator, multiplier}. Divide: {remainder, quotient}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  // Multiplicand magnitude (multiply) or divisor magnitude (divide).
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;

  // Start-time operand preparation.
  logic             st_signed, st_div, st_div_zero, st_a_neg, st_b_neg;
  logic [WIDTH-1:0] st_a_mag, st_b_mag;

  always_comb begin
    st_signed   = ~i_con_Op[0];
    st_div      = i_con_Op[1];
    st_div_zero = st_div & (i_data_B == '0);
    // Divide by zero runs A through unsigned so the remainder comes out as A
    // verbatim and no sign fix is applied.
    st_a_neg    = st_signed & i_data_A[WIDTH-1] & ~st_div_zero;
    st_b_neg    = st_signed & i_data_B[WIDTH-1];
    st_a_mag    = st_a_neg ? ('0 - i_data_A) : i_data_A;
    st_b_mag    = st_b_neg ? ('0 - i_data_B) : i_data_B;
  end

  // Shared add/subtract path. WIDTH+2 bits: divide needs the bit shifted out
  // of the remainder plus a borrow bit; multiply needs the carry-out.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] add_a, add_b, add_res;
  logic             borrow;

  always_comb begin
    rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    add_a   = is_div_q ? {1'b0, rem_sh} : {2'b00, acc_q[2*WIDTH-1:WIDTH]};
    add_b   = {2'b00, opb_q};
    add_res = is_div_q ? (add_a - add_b) : (add_a + add_b);
    borrow  = add_res[WIDTH+1];
  end

  // Sign fix-up values for the SIGN step.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    prod_fix = neg_res_q ? ('0 - acc_q) : acc_q;
    quot_fix = neg_res_q ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? ('0 - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (i_con_Start) begin
          // Start wins over any simultaneous Mt write.
          is_div_d  = st_div;
          neg_res_d = st_a_neg ^ st_b_neg;
          neg_rem_d = st_div & st_a_neg;
          cnt_d     = '0;
          if (st_div) begin
            acc_d = {{WIDTH{1'b0}}, st_a_mag};
            opb_d = st_b_mag;
          end else begin
            acc_d = {{WIDTH{1'b0}}, st_b_mag};
            opb_d = st_a_mag;
          end
          state_d = StCalc;
        end else begin
          if (i_con_MtHi) hi_d = i_data_A;
          if (i_con_MtLo) lo_d = i_data_A;
          state_d = StIdle;
        end
      end

      StCalc: begin
        if (is_div_q) begin
          if (!borrow) acc_d = {add_res[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else         acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
          if (acc_q[0]) acc_d = {add_res[WIDTH:0], acc_q[WIDTH-1:1]};
          else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StSign;
      end

      StSign: begin
        if (is_div_q) begin
          lo_d = quot_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        state_d = StDone;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign o_data_Hi  = hi_q;
  assign o_data_Lo  = lo_q;
  assign o_con_Busy = (state_q == StCalc) || (state_q == StSign);
  assign o_con_Done = (state_q == StDone);

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a, b;
  logic          mt_hi, mt_lo;
  logic [W-1:0]  hi, lo;
  logic          busy, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_con_Start (start),
    .i_con_Op    (op),
    .i_data_A    (a),
    .i_data_B    (b),
    .i_con_MtHi  (mt_hi),
    .i_con_MtLo  (mt_lo),
    .o_data_Hi   (hi),
    .o_data_Lo   (lo),
    .o_con_Busy  (busy),
    .o_con_Done  (done)
  );

  // Reference: {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint    sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = '0;
    case (o)
      2'd0: p = 64'(sx * sy);
      2'd1: p = {32'd0, x} * {32'd0, y};
      2'd2: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else        p = {x % y, x / y};
      end
    endcase
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called n0 cycles after the start edge; waits out the op and checks it.
  task automatic finish_op(input string tag, input int n0, input logic [63:0] exp);
    int n;
    n = n0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check({tag, " busy_cycles"}, 64'(n), 64'd33);
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " hilo"}, {hi, lo}, exp);
    tick();
    check({tag, " done_pulse"}, 64'(done), 64'd0);
    check({tag, " hilo_hold"}, {hi, lo}, exp);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y);
    logic [63:0] exp;
    exp   = model(o, x, y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
    // Operands are free to change once captured.
    a     = $urandom;
    b     = $urandom;
    op    = 2'($urandom);
    check({tag, " busy_start"}, 64'(busy), 64'd1);
    finish_op(tag, 0, exp);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  ro;
    logic        seen;

    rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0; mt_hi = 1'b0; mt_lo = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset hilo", {hi, lo}, 64'd0);
    check("reset busy_done", {62'd0, busy, done}, 64'd0);

    run_op("mult -3*5", 2'd0, 32'hFFFF_FFFD, 32'd5);
    run_op("multu max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div -7/2", 2'd2, 32'hFFFF_FFF9, 32'd2);
    run_op("divu 100/7", 2'd3, 32'd100, 32'd7);
    run_op("div min/-1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div by0", 2'd2, 32'hFFFF_FFF9, 32'd0);
    run_op("divu by0", 2'd3, 32'd123, 32'd0);

    // Start and Mt requests while busy are ignored.
    start = 1'b1; op = 2'd1; a = 32'd3; b = 32'd4;
    tick();
    start = 1'b0;
    repeat (4) tick();
    mt_hi = 1'b1; a = 32'h55;
    tick();
    mt_hi = 1'b0;
    check("busy mthi ignored", 64'(hi), 64'd123);
    repeat (4) tick();
    start = 1'b1; a = 32'd9; b = 32'd9;
    tick();
    start = 1'b0;
    finish_op("busy restart ignored", 10, {32'd0, 32'd12});

    // Mt writes in idle.
    mt_hi = 1'b1; mt_lo = 1'b1; a = 32'hDEAD_BEEF;
    tick();
    mt_hi = 1'b0; mt_lo = 1'b0;
    check("mt both", {hi, lo}, {32'hDEAD_BEEF, 32'hDEAD_BEEF});
    mt_lo = 1'b1; a = 32'h0000_1111;
    tick();
    mt_lo = 1'b0;
    check("mt lo only", {hi, lo}, {32'hDEAD_BEEF, 32'h0000_1111});

    // Start together with MtLo: Mt dropped.
    start = 1'b1; mt_lo = 1'b1; op = 2'd0; a = 32'd2; b = 32'd3;
    tick();
    start = 1'b0; mt_lo = 1'b0;
    check("start+mt lo kept", 64'(lo), 64'h0000_1111);
    finish_op("start+mt result", 0, {32'd0, 32'd6});

    // Reset mid-operation.
    start = 1'b1; op = 2'd0; a = 32'd7; b = 32'd7;
    tick();
    start = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset hilo", {hi, lo}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen = 1'b1;
      tick();
    end
    check("midreset no done", 64'(seen), 64'd0);

    // Randomized ops against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = '0;
      if ($urandom_range(0, 7) == 0) rb = rb & 32'h0000_00FF;
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      run_op($sformatf("rand%0d op%0d %h %h", i, ro, ra, rb), ro, ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
